// File: rtl/freq_divider_prog.sv
// Runtime-programmable integer clock divider with 50% duty for even and odd divisors,
// period-boundary divisor reload, clean start/stop, off (N=0) and bypass (N=1) modes.
`timescale 1ns/1ps
module freq_divider_prog #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_n,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_active,
  output logic             load_ack
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] pending;
  logic             pend_v;
  logic             p;
  logic             q;

  logic             div_ge2;
  logic             div_is1;
  logic             wrap;
  logic             req_v;
  logic [WIDTH-1:0] req_val;
  logic             apply;
  logic [WIDTH-1:0] thr;
  logic             p_nxt;
  logic             tick_nxt;

  // Period-boundary detection and reload arbitration. A fresh div_load wins over pending.
  always_comb begin
    div_ge2 = (div_active >= TWO);
    div_is1 = (div_active == ONE);
    wrap    = (state == ST_RUN) && div_ge2 && (cnt == div_active - ONE);
    req_v   = pend_v | div_load;
    req_val = div_load ? div_n : pending;
    apply   = req_v && (wrap || (state == ST_IDLE) || !div_ge2);
    thr     = div_active[0] ? (div_active >> 1) : ((div_active >> 1) - ONE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en) state_nxt = ST_RUN;
      ST_RUN:  if (!en && (wrap || !div_ge2)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt  = cnt + ONE;
    if ((state != ST_RUN) || !div_ge2 || wrap || apply) cnt_nxt = '0;
    p_nxt    = (state == ST_RUN) && div_ge2 && (cnt <= thr);
    tick_nxt = (state == ST_RUN) && (div_is1 || (div_ge2 && (cnt == '0)));
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      p          <= 1'b0;
      tick       <= 1'b0;
      load_ack   <= 1'b0;
      div_active <= DEF;
      pending    <= '0;
      pend_v     <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      p        <= p_nxt;
      tick     <= tick_nxt;
      load_ack <= apply;
      if (apply) begin
        div_active <= req_val;
        pend_v     <= 1'b0;
      end else if (div_load) begin
        pending <= div_n;
        pend_v  <= 1'b1;
      end
    end
  end

  // Half-cycle delayed copy of p; ANDing it in gives odd divisors their 50% duty.
  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= p;
  end

  always_comb begin
    if ((state == ST_RUN) && div_is1) clk_out = clk_in;
    else if (div_active[0])           clk_out = p & q;
    else                              clk_out = p;
  end

endmodule
